// File: rtl/lfsr_sng_multi.sv
// Shared Fibonacci LFSR feeding NCH rotation-scrambled SNG channels.
// Define LFSR_ZERO_STATE_EN to splice the all-zero state into the cycle.
module lfsr_sng_multi #(
    parameter int                 WIDTH        = 8,
    parameter logic [WIDTH-1:0]   TAPS         = WIDTH'('h8E),
    parameter int                 NCH          = 4,
    parameter int                 ROT_STEP     = 3,
    parameter logic [WIDTH-1:0]   DEFAULT_SEED = WIDTH'(1)
) (
    input  logic                   TRIG,
    input  logic                   RESET,
    input  logic                   EN,
    input  logic                   LOAD,
    input  logic [WIDTH-1:0]       SEED,
    input  logic [WIDTH-1:0]       X,
    output logic [WIDTH-1:0]       STATE,
    output logic [NCH*WIDTH-1:0]   RND,
    output logic [NCH-1:0]         SBIT,
    output logic [WIDTH-1:0]       CNT,
    output logic                   WRAP
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic [NCH-1:0]   sbit_q, sbit_d;

    logic [WIDTH-1:0] seed_v;
    logic [WIDTH-1:0] step_v;
    logic             fb;
    logic [WIDTH-1:0] rnd_w [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_rot
        localparam int R = (k * ROT_STEP) % WIDTH;
        if (R == 0) begin : g_id
            assign rnd_w[k] = state_q;
        end else begin : g_rl
            assign rnd_w[k] = {state_q[WIDTH-1-R:0], state_q[WIDTH-1:WIDTH-R]};
        end
        assign RND[k*WIDTH +: WIDTH] = rnd_w[k];
    end

    always_comb begin
        fb = ^(state_q & TAPS);
`ifdef LFSR_ZERO_STATE_EN
        // Flipping fb when the low bits are zero splices 0 into the cycle.
        fb = fb ^ (state_q[WIDTH-2:0] == '0);
        seed_v = SEED;
`else
        seed_v = (SEED == '0) ? DEFAULT_SEED : SEED;
`endif
        step_v = {state_q[WIDTH-2:0], fb};
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            sbit_d[k] = (rnd_w[k] < X);
        end
        if (LOAD) begin
            state_d = seed_v;
            start_d = seed_v;
            cnt_d   = '0;
            sbit_d  = '0;
        end else if (EN) begin
            state_d = step_v;
            if (step_v == start_q) begin
                wrap_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge TRIG) begin
        if (RESET) begin
            state_q <= seed_v;
            start_q <= seed_v;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            sbit_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            sbit_q  <= sbit_d;
        end
    end

    assign STATE = state_q;
    assign CNT   = cnt_q;
    assign WRAP  = wrap_q;
    assign SBIT  = sbit_q;

endmodule
